// File: rtl/flash_boot_loader.sv
// Boot loader: copies the flash reader's word stream into instruction memory,
// optionally verifies a zero-sum checksum, then releases the CPU from reset.
module flash_boot_loader #(
    parameter int WORDS    = 128,
    parameter int ADDR_W   = 7,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [15:0]       DATA1,
    input  logic              NEW_DATA1,
    input  logic              FLASH_IDLE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_DATA,
    output logic              MEM_WE,
    output logic              CPU_RESET,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_W:0]   WORD_CNT
);

    localparam logic [ADDR_W:0] L_WORDS = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_nd_prev;
    logic [15:0]       r_sum;
    logic [15:0]       w_sum_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       r_data;
    logic [15:0]       w_data_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_reset;
    logic              w_edge;

    assign w_edge = NEW_DATA1 & ~r_nd_prev;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decode; an edge in the same cycle as FLASH_IDLE is written first
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_we_nxt    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_edge && (r_cnt < L_WORDS)) begin
                    w_addr_nxt = r_cnt[ADDR_W-1:0];
                    w_data_nxt = DATA1;
                    w_we_nxt   = 1'b1;
                    w_cnt_nxt  = r_cnt + L_ONE;
                    w_sum_nxt  = r_sum + DATA1;
                end else begin
                    w_we_nxt   = 1'b0;
                end
                if (w_cnt_nxt >= L_WORDS) begin
                    w_state_nxt = ST_CHECK;
                end else if (FLASH_IDLE) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if ((CHECK_EN == 1'b0) || (r_sum == 16'h0000)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FAIL;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_FAIL;
        endcase
    end

    // Datapath and status registers; status follows the state being entered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_nd_prev   <= 1'b0;
            r_sum       <= 16'h0000;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= 16'h0000;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_nd_prev   <= NEW_DATA1;
            r_sum       <= w_sum_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_we        <= w_we_nxt;
            r_done      <= (w_state_nxt == ST_RUN);
            r_error     <= (w_state_nxt == ST_FAIL);
            r_cpu_reset <= (w_state_nxt != ST_RUN);
        end
    end

    assign MEM_ADDR  = r_addr;
    assign MEM_DATA  = r_data;
    assign MEM_WE    = r_we;
    assign CPU_RESET = r_cpu_reset;
    assign DONE      = r_done;
    assign ERROR     = r_error;
    assign WORD_CNT  = r_cnt;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench: a 4-word checksummed loader and a default-size unchecked
// loader share the stimulus; writes of each are logged and checked per test.
module tb_flash_boot_loader;

    logic        CLK;
    logic        RST;
    logic [15:0] DATA1;
    logic        NEW_DATA1;
    logic        FLASH_IDLE;

    logic [1:0]  a_addr;
    logic [15:0] a_data;
    logic        a_we, a_cpu_reset, a_done, a_error;
    logic [2:0]  a_cnt;

    logic [6:0]  b_addr;
    logic [15:0] b_data;
    logic        b_we, b_cpu_reset, b_done, b_error;
    logic [7:0]  b_cnt;

    int total;
    int bad;
    int a_wa[$];
    int a_wd[$];
    int b_wa[$];
    int b_wd[$];

    flash_boot_loader #(.WORDS(4), .ADDR_W(2), .CHECK_EN(1'b1)) u_dut4 (
        .CLK(CLK), .RST(RST), .DATA1(DATA1), .NEW_DATA1(NEW_DATA1),
        .FLASH_IDLE(FLASH_IDLE), .MEM_ADDR(a_addr), .MEM_DATA(a_data),
        .MEM_WE(a_we), .CPU_RESET(a_cpu_reset), .DONE(a_done),
        .ERROR(a_error), .WORD_CNT(a_cnt)
    );

    flash_boot_loader #(.WORDS(128), .ADDR_W(7), .CHECK_EN(1'b0)) u_dut128 (
        .CLK(CLK), .RST(RST), .DATA1(DATA1), .NEW_DATA1(NEW_DATA1),
        .FLASH_IDLE(FLASH_IDLE), .MEM_ADDR(b_addr), .MEM_DATA(b_data),
        .MEM_WE(b_we), .CPU_RESET(b_cpu_reset), .DONE(b_done),
        .ERROR(b_error), .WORD_CNT(b_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Record every memory write seen by either instance
    always @(negedge CLK) begin
        if (a_we === 1'b1) begin
            a_wa.push_back(int'(a_addr));
            a_wd.push_back(int'(a_data));
        end
        if (b_we === 1'b1) begin
            b_wa.push_back(int'(b_addr));
            b_wd.push_back(int'(b_data));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST        = 1'b1;
        NEW_DATA1  = 1'b0;
        FLASH_IDLE = 1'b0;
        DATA1      = 16'h0000;
        tick(2);
        RST = 1'b0;
        a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
    endtask

    task automatic send_word(input logic [15:0] d);
        DATA1     = d;
        NEW_DATA1 = 1'b1;
        tick(1);
        NEW_DATA1 = 1'b0;
        DATA1     = 16'hDEAD;
        tick(3);
    endtask

    task automatic test_reset();
        RST = 1'b1; NEW_DATA1 = 1'b0; FLASH_IDLE = 1'b0; DATA1 = 16'h0000;
        tick(2);
        total++;
        if ({a_addr, a_data, a_we, a_cpu_reset, a_done, a_error, a_cnt} !==
            {2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_a: got addr=%0d data=%h we=%b cpr=%b done=%b err=%b cnt=%0d want 0/0000/0/1/0/0/0",
                     a_addr, a_data, a_we, a_cpu_reset, a_done, a_error, a_cnt);
        end
        total++;
        if ({b_addr, b_data, b_we, b_cpu_reset, b_done, b_error, b_cnt} !==
            {7'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_b: got cpr=%b done=%b err=%b cnt=%0d want 1/0/0/0",
                     b_cpu_reset, b_done, b_error, b_cnt);
        end
        RST = 1'b0;
        a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
    endtask

    task automatic test_good_image();
        logic [15:0] img [4];
        img[0] = 16'h0001; img[1] = 16'h0002; img[2] = 16'h0003; img[3] = 16'hFFFA;
        apply_reset();
        for (int i = 0; i < 3; i++) send_word(img[i]);
        // last word arrives together with FLASH_IDLE: must still be written and pass
        DATA1 = img[3]; NEW_DATA1 = 1'b1; FLASH_IDLE = 1'b1;
        tick(1);
        NEW_DATA1 = 1'b0;
        total++;
        if ({a_we, a_done, a_cpu_reset, a_error} !== 4'b1010) begin
            bad++;
            $display("FAIL good_check_cycle: we/done/cpr/err=%b%b%b%b want 1010",
                     a_we, a_done, a_cpu_reset, a_error);
        end
        tick(1);
        total++;
        if ({a_we, a_done, a_cpu_reset, a_error} !== 4'b0100) begin
            bad++;
            $display("FAIL good_run: we/done/cpr/err=%b%b%b%b want 0100",
                     a_we, a_done, a_cpu_reset, a_error);
        end
        tick(2);
        total++;
        if (a_wa.size() !== 4) begin
            bad++;
            $display("FAIL good_nwrites: got %0d want 4", a_wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (a_wa[i] !== i || a_wd[i] !== int'(img[i])) begin
                    bad++;
                    $display("FAIL good_write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                             i, a_wa[i], a_wd[i], i, img[i]);
                end
            end
        end
        total++;
        if (a_cnt !== 3'd4) begin
            bad++;
            $display("FAIL good_cnt: got %0d want 4", a_cnt);
        end
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        send_word(16'h0001); send_word(16'h0002); send_word(16'h0003); send_word(16'hFFFB);
        FLASH_IDLE = 1'b1;
        tick(2);
        total++;
        if ({a_done, a_cpu_reset, a_error} !== 3'b011) begin
            bad++;
            $display("FAIL badsum_status: done/cpr/err=%b%b%b want 011", a_done, a_cpu_reset, a_error);
        end
        total++;
        if (a_wa.size() !== 4 || a_cnt !== 3'd4) begin
            bad++;
            $display("FAIL badsum_writes: got writes=%0d cnt=%0d want 4/4", a_wa.size(), a_cnt);
        end
    endtask

    task automatic test_short_image();
        apply_reset();
        send_word(16'hAAAA); send_word(16'h5555);
        FLASH_IDLE = 1'b1;
        tick(1);
        total++;
        if ({a_done, a_cpu_reset, a_error} !== 3'b011 || a_cnt !== 3'd2) begin
            bad++;
            $display("FAIL short_fail: done/cpr/err=%b%b%b cnt=%0d want 011 cnt=2",
                     a_done, a_cpu_reset, a_error, a_cnt);
        end
        send_word(16'h1111); send_word(16'h2222);
        total++;
        if (a_wa.size() !== 2 || a_cnt !== 3'd2 || a_error !== 1'b1) begin
            bad++;
            $display("FAIL short_frozen: got writes=%0d cnt=%0d err=%b want 2/2/1",
                     a_wa.size(), a_cnt, a_error);
        end
    endtask

    task automatic test_hold_strobe();
        apply_reset();
        DATA1 = 16'h1234; NEW_DATA1 = 1'b1;
        tick(5);
        NEW_DATA1 = 1'b0;
        tick(2);
        total++;
        if (a_wa.size() !== 1) begin
            bad++;
            $display("FAIL hold_nwrites: got %0d want 1", a_wa.size());
        end else begin
            total++;
            if (a_wa[0] !== 0 || a_wd[0] !== 32'h1234) begin
                bad++;
                $display("FAIL hold_write: got addr=%0d data=%h want 0/1234", a_wa[0], a_wd[0]);
            end
        end
        total++;
        if (a_cnt !== 3'd1 || b_cnt !== 8'd1) begin
            bad++;
            $display("FAIL hold_cnt: got a=%0d b=%0d want 1/1", a_cnt, b_cnt);
        end
    endtask

    task automatic test_full_128();
        apply_reset();
        for (int i = 0; i < 128; i++) begin
            DATA1 = 16'(i); NEW_DATA1 = 1'b1;
            tick(1);
            NEW_DATA1 = 1'b0;
            tick(1);
        end
        tick(1);
        total++;
        if ({b_done, b_cpu_reset, b_error} !== 3'b100 || b_cnt !== 8'd128) begin
            bad++;
            $display("FAIL full_done: done/cpr/err=%b%b%b cnt=%0d want 100 cnt=128",
                     b_done, b_cpu_reset, b_error, b_cnt);
        end
        total++;
        if (b_wa.size() !== 128) begin
            bad++;
            $display("FAIL full_nwrites: got %0d want 128", b_wa.size());
        end else begin
            for (int i = 0; i < 128; i++) begin
                total++;
                if (b_wa[i] !== i || b_wd[i] !== i) begin
                    bad++;
                    $display("FAIL full_write%0d: got addr=%0d data=%h want %0d/%h",
                             i, b_wa[i], b_wd[i], i, i);
                end
            end
        end
        DATA1 = 16'hFFFF; NEW_DATA1 = 1'b1;
        tick(1);
        NEW_DATA1 = 1'b0;
        tick(2);
        total++;
        if (b_wa.size() !== 128 || b_cnt !== 8'd128 || b_done !== 1'b1) begin
            bad++;
            $display("FAIL full_extra: got writes=%0d cnt=%0d done=%b want 128/128/1",
                     b_wa.size(), b_cnt, b_done);
        end
    endtask

    task automatic test_midload_reset();
        apply_reset();
        send_word(16'h0101); send_word(16'h0202); send_word(16'h0303);
        RST = 1'b1;
        tick(1);
        total++;
        if ({a_addr, a_data, a_we, a_cpu_reset, a_done, a_error, a_cnt} !==
            {2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL midreset_outputs: got addr=%0d data=%h we=%b cpr=%b done=%b err=%b cnt=%0d want 0/0000/0/1/0/0/0",
                     a_addr, a_data, a_we, a_cpu_reset, a_done, a_error, a_cnt);
        end
        RST = 1'b0;
        a_wa.delete(); a_wd.delete();
        send_word(16'h1000); send_word(16'h2000); send_word(16'h3000); send_word(16'hA000);
        FLASH_IDLE = 1'b1;
        tick(1);
        total++;
        if ({a_done, a_cpu_reset, a_error} !== 3'b100) begin
            bad++;
            $display("FAIL midreset_done: done/cpr/err=%b%b%b want 100", a_done, a_cpu_reset, a_error);
        end
        total++;
        if (a_wa.size() !== 4 || a_wa[0] !== 0 || a_wd[0] !== 32'h1000 || a_wa[3] !== 3 || a_wd[3] !== 32'hA000) begin
            bad++;
            $display("FAIL midreset_writes: got n=%0d first=%0d/%h last=%0d/%h want 4 0/1000 3/a000",
                     a_wa.size(), a_wa[0], a_wd[0], a_wa[3], a_wd[3]);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        RST        = 1'b1;
        NEW_DATA1  = 1'b0;
        FLASH_IDLE = 1'b0;
        DATA1      = 16'h0000;
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_short_image();
        test_hold_strobe();
        test_full_128();
        test_midload_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
